// File: rtl/gba_timer_bank.sv
// Bank of GBA-style count-up timers with per-channel reload, prescaler, cascade and IRQ.
// Register window: addr[0] selects counter/reload (0) or control (1); upper bits select the channel.
module gba_timer_bank #(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 16,
  parameter int PS_W   = 10
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic [$clog2(NUM_CH):0]  io_addr,
  input  logic [CNT_W-1:0]         io_data_in,
  input  logic                     io_write,
  input  logic                     io_read,
  output logic [CNT_W-1:0]         io_data_out,
  output logic [NUM_CH-1:0]        overflow,
  output logic [NUM_CH-1:0]        irq
);

  localparam int AW = $clog2(NUM_CH) + 1;

  logic [AW-1:0]    ch_sel;
  logic             reg_sel;
  logic             ch_valid;
  logic [CNT_W-1:0] cnt_rd  [NUM_CH];
  logic [7:0]       ctrl_rd [NUM_CH];
  logic [CNT_W-1:0] rd_next;

  assign ch_sel   = io_addr >> 1;
  assign reg_sel  = io_addr[0];
  assign ch_valid = (ch_sel < AW'(NUM_CH));

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : ch_gen
      logic [CNT_W-1:0] cnt_reg;
      logic [CNT_W-1:0] reload_reg;
      logic [PS_W-1:0]  ps_reg;
      logic [PS_W-1:0]  ps_lim;
      logic [1:0]       ps_sel_reg;
      logic             casc_reg;
      logic             irq_en_reg;
      logic             en_reg;
      logic             ovf_reg;
      logic             irq_reg;
      logic             ctrl_wr;
      logic             reload_wr;
      logic             casc_eff;
      logic             up_wrap;
      logic             tick;
      logic             wrap;

      assign ctrl_wr   = io_write && ch_valid && (ch_sel == AW'(gi)) && reg_sel;
      assign reload_wr = io_write && ch_valid && (ch_sel == AW'(gi)) && !reg_sel;

      // Channel 0 has no upstream, so its cascade bit is stored but never used.
      if (gi == 0) begin : g_head
        assign up_wrap  = 1'b0;
        assign casc_eff = 1'b0;
      end else begin : g_link
        assign up_wrap  = ch_gen[gi-1].wrap;
        assign casc_eff = casc_reg;
      end

      always_comb begin
        ps_lim = '0;
        case (ps_sel_reg)
          2'd0:    ps_lim = '0;
          2'd1:    ps_lim = PS_W'(63);
          2'd2:    ps_lim = PS_W'(255);
          default: ps_lim = PS_W'(1023);
        endcase
      end

      // A control write owns the channel for that cycle: the prescaler restarts and no count is taken.
      assign tick = casc_eff ? up_wrap : (ps_reg == ps_lim);
      assign wrap = en_reg && !ctrl_wr && tick && (cnt_reg == {CNT_W{1'b1}});

      always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
          cnt_reg    <= '0;
          reload_reg <= '0;
          ps_reg     <= '0;
          ps_sel_reg <= '0;
          casc_reg   <= 1'b0;
          irq_en_reg <= 1'b0;
          en_reg     <= 1'b0;
          ovf_reg    <= 1'b0;
          irq_reg    <= 1'b0;
        end else begin
          ovf_reg <= wrap;
          irq_reg <= wrap && irq_en_reg;
          if (reload_wr) begin
            reload_reg <= io_data_in;
          end
          if (ctrl_wr) begin
            ps_sel_reg <= io_data_in[1:0];
            casc_reg   <= io_data_in[2];
            irq_en_reg <= io_data_in[6];
            en_reg     <= io_data_in[7];
            ps_reg     <= '0;
            if (!en_reg && io_data_in[7]) begin
              cnt_reg <= reload_reg;
            end
          end else if (en_reg) begin
            if (!casc_eff) begin
              ps_reg <= (ps_reg == ps_lim) ? '0 : ps_reg + 1'b1;
            end
            if (tick) begin
              cnt_reg <= wrap ? reload_reg : cnt_reg + 1'b1;
            end
          end
        end
      end

      assign cnt_rd[gi]   = cnt_reg;
      assign ctrl_rd[gi]  = {en_reg, irq_en_reg, 3'b000, casc_reg, ps_sel_reg};
      assign overflow[gi] = ovf_reg;
      assign irq[gi]      = irq_reg;
    end
  endgenerate

  always_comb begin
    rd_next = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (ch_valid && (ch_sel == AW'(i))) begin
        rd_next = reg_sel ? CNT_W'(ctrl_rd[i]) : cnt_rd[i];
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      io_data_out <= '0;
    end else if (io_read) begin
      io_data_out <= rd_next;
    end
  end

endmodule

// File: doc/gba_timer_bank.md
Name: gba_timer_bank

Overview:
- Parametrised bank of GBA-style count-up timers; NUM_CH channels, each with reload, prescaler, cascade and IRQ.
- Sits behind io_register on the memory-side IO bus (TM0CNT..TM3CNT window).
- Feeds per-channel overflow/IRQ pulses to the interrupt logic and to future sound DMA.
- Generalises the fixed 4-timer GBA arrangement in channel count, counter width and prescaler base.

Parameters:
- NUM_CH, 4, number of timer channels (1..8).
- CNT_W, 16, counter and reload width in bits.
- PS_W, 10, per-channel prescaler counter width; must satisfy 2^PS_W >= largest divider (1024).

Ports:
- clk  in  1  system clock (25 MHz domain, same as io bus).
- rstn  in  1  asynchronous active-low reset.
- io_addr  in  $clog2(NUM_CH)+1  addr[0] selects register (0 = counter/reload, 1 = control); upper bits select channel.
- io_data_in  in  CNT_W  write data.
- io_write  in  1  single-cycle write strobe.
- io_read  in  1  single-cycle read strobe.
- io_data_out  out  CNT_W  registered read data.
- overflow  out  NUM_CH  one-cycle pulse per channel on wrap.
- irq  out  NUM_CH  one-cycle pulse on wrap when the channel's irq_en = 1.

Behaviour:
- Reset (async): all counters, reloads, controls, prescaler counts, io_data_out, overflow and irq go to 0.
- Control register bits:
  - [1:0] prescaler select: divide by 1, 64, 256 or 1024.
  - [2] cascade.
  - [6] irq_en.
  - [7] enable.
  - Other bits read as 0.
- Write, reg 0: sets reload only. The live counter is unchanged; the new reload takes effect at the next wrap or the next enable rising edge.
- Write, reg 1: stores the control bits and clears that channel's prescaler count.
  - If enable goes 0 to 1: counter <= reload on that same edge, and no increment happens that cycle.
- Read: io_data_out <= current counter (reg 0) or control (reg 1) on the edge of io_read. Latency is 1 cycle; the value holds until the next read.
  - A read and a write to the same register in the same cycle returns the pre-write value.
- Tick source, non-cascade: the per-channel prescaler count increments every clk while enable = 1. A tick is emitted and the count returns to 0 when the count equals divider-1. Divider 1 means a tick every cycle.
- Tick source, cascade (channels 1..NUM_CH-1): tick = overflow of channel ch-1 in the same cycle.
  - The chain is combinational through all channels, so a full cascade wrap resolves in one cycle.
  - The prescaler is ignored while cascade = 1.
  - Cascade on channel 0 is ignored; channel 0 uses its prescaler.
- Count: on a tick with enable = 1, if counter = 2^CNT_W-1 then counter <= reload, overflow[ch] = 1 for one cycle, and irq[ch] = irq_en. Otherwise counter <= counter+1.
- Disabled channel: counter and prescaler hold, and no overflow is produced, even if the upstream channel overflows.
- Reload = 2^CNT_W-1 with divider 1: wraps every cycle, and overflow stays high continuously.
- Out-of-range channel index (NUM_CH not a power of 2): writes are ignored and reads return 0.
- Reset asserted mid-count: immediate clear. After release, all channels stay idle until software re-enables them.

Test Plan:
- Reset then read ch0 reg1 -> io_data_out = 0x0000 one cycle after io_read; overflow = 0 and irq = 0.
- ch0 reload = 0xFFFC, ctrl = 0x0080 (div 1) -> counter reads FFFC, FFFD, FFFE, FFFF on successive cycles; overflow[0] pulses on the 4th tick edge; counter returns to FFFC; irq[0] stays 0.
- ch1 reload = 0xFFFF, ctrl = 0x00C1 (div 64, irq_en) -> irq[1] pulses exactly every 64 clk; the first pulse comes 64 cycles after the enable write.
- Cascade: ch0 reload = 0xFFFE, ctrl = 0x0080; ch1 reload = 0xFFFE, ctrl = 0x00C4 -> ch1 increments once per 2 clk; overflow[1] and irq[1] pulse in the same cycle as every 2nd overflow[0].
- Reload rewrite while running: ch2 running at reload 0x0000, then write reload = 0x8000 -> counter continues unchanged until it reaches FFFF, then wraps to 0x8000.
- Disable mid-count at counter 0x1234, wait 100 cycles, re-enable -> counter is 0x1234 while disabled; after re-enable the counter is loaded with reload, not 0x1235; no overflow occurs during the disabled window.
